// File: rtl/cache_membus_adapter.sv
// -----------------------------------------------------------------------------
// cache_membus_adapter
//
// Purpose:
//   Bridges the direct-mapped cache controller's line-wide memory port to a
//   narrow external word bus. A write-back request is sent out as a burst of
//   word beats. A fill request issues word-address beats and gathers the
//   returning words into one line. Completion is signalled with a
//   single-cycle ready pulse.
//
// Ports:
//   clk              clock (single domain)
//   reset_n          synchronous active-low reset
//   mem_req_valid    line request present (held by the cache controller)
//   mem_req_rw       1 = write-back line, 0 = fill line
//   mem_req_addr     byte address; low line-offset bits ignored
//   mem_req_data     write-back line, word 0 in the low bits
//   mem_resp_ready   one-cycle completion pulse
//   mem_resp_data    assembled fill line; holds until the next fill completes
//   bus_req          beat request
//   bus_we           beat is a write
//   bus_addr         word-aligned beat address
//   bus_wdata        write beat data
//   bus_gnt          beat accepted when bus_req & bus_gnt
//   bus_rvalid       read word returning (issue order, latency >= 1)
//   bus_rdata        read word data
//
// Build option:
//   MEMBUS_CRITICAL_WORD_FIRST_EN - read bursts start at the requested word
//   and wrap around the line; writes always go out in order 0..BEATS-1.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a line request; latches address, direction, data
// WR    | issuing write beats in order, one per grant
// RD    | issuing read address beats while collecting returned words
// RESP  | ready pulse for one cycle, then back to IDLE
// -----------------------------------------------------------------------------
module cache_membus_adapter #(
    parameter int BUS_W  = 32,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_req_valid,
    input  logic              mem_req_rw,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_data,
    output logic              mem_resp_ready,
    output logic [LINE_W-1:0] mem_resp_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BUS_W-1:0]  bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [BUS_W-1:0]  bus_rdata
);

    localparam int BEATS  = LINE_W / BUS_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int WOFF_W = $clog2(BUS_W / 8);
    localparam int LOFF_W = BEAT_W + WOFF_W;
    localparam int TAG_W  = ADDR_W - LOFF_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [BEAT_W-1:0]   b0_q, b0_d;
    logic [BEAT_W-1:0]   iss_beat_q, iss_beat_d;
    logic                iss_done_q, iss_done_d;
    logic [BEAT_W-1:0]   ret_beat_q, ret_beat_d;
    logic                ret_done_q, ret_done_d;
    logic [LINE_W-1:0]   lbuf_q, lbuf_d;

    logic                resp_ready_q, resp_ready_d;
    logic [LINE_W-1:0]   resp_data_q, resp_data_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [BUS_W-1:0]    bus_wdata_q, bus_wdata_d;

    logic [TAG_W-1:0]    req_tag;
    logic [BEAT_W-1:0]   start_beat;
    logic [BEAT_W-1:0]   iss_beat_nx;
    logic [BEAT_W-1:0]   iss_lane_nx;
    logic [BEAT_W-1:0]   ret_lane;
    logic [BEAT_W:0]     iss_cnt;
    logic [BEAT_W:0]     ret_cnt;
    logic                gnt_fire;
    logic                rv_fire;
    logic                unused_addr_bits;

    assign req_tag     = mem_req_addr[ADDR_W-1:LOFF_W];
    assign iss_beat_nx = iss_beat_q + BEAT_W'(1);
    assign iss_lane_nx = b0_q + iss_beat_nx;
    assign ret_lane    = b0_q + ret_beat_q;

    // Counts 0..BEATS are the done flag on top of the wrapped beat index, so a
    // finished counter reads as BEATS and never wraps into an extra beat.
    assign iss_cnt = {iss_done_q, iss_beat_q};
    assign ret_cnt = {ret_done_q, ret_beat_q};

    assign gnt_fire = bus_req_q & bus_gnt;
    // Only words that have an outstanding issued address are accepted; any
    // other rvalid (stray, or outside a fill) is dropped.
    assign rv_fire  = (state_q == S_RD) & bus_rvalid & (ret_cnt < iss_cnt);

    // Word/byte offset bits only matter to the critical-word-first start beat.
    assign unused_addr_bits = ^mem_req_addr[LOFF_W-1:0];

    always_comb begin
`ifdef MEMBUS_CRITICAL_WORD_FIRST_EN
        start_beat = mem_req_rw ? '0 : mem_req_addr[LOFF_W-1:WOFF_W];
`else
        start_beat = '0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        wline_d      = wline_q;
        b0_d         = b0_q;
        iss_beat_d   = iss_beat_q;
        iss_done_d   = iss_done_q;
        ret_beat_d   = ret_beat_q;
        ret_done_d   = ret_done_q;
        lbuf_d       = lbuf_q;
        resp_ready_d = 1'b0;
        resp_data_d  = resp_data_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (mem_req_valid) begin
                    tag_d      = req_tag;
                    wline_d    = mem_req_data;
                    b0_d       = start_beat;
                    iss_beat_d = '0;
                    iss_done_d = 1'b0;
                    ret_beat_d = '0;
                    ret_done_d = 1'b0;
                    bus_req_d  = 1'b1;
                    bus_we_d   = mem_req_rw;
                    bus_addr_d = {req_tag, start_beat, {WOFF_W{1'b0}}};
                    if (mem_req_rw) begin
                        bus_wdata_d = mem_req_data[BUS_W-1:0];
                    end
                    state_d    = mem_req_rw ? S_WR : S_RD;
                end
            end

            S_WR: begin
                if (gnt_fire) begin
                    if (iss_beat_q == LAST_BEAT) begin
                        iss_beat_d   = '0;
                        iss_done_d   = 1'b1;
                        bus_req_d    = 1'b0;
                        bus_we_d     = 1'b0;
                        resp_ready_d = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        iss_beat_d  = iss_beat_nx;
                        bus_addr_d  = {tag_q, iss_beat_nx, {WOFF_W{1'b0}}};
                        bus_wdata_d = wline_q[int'(iss_beat_nx) * BUS_W +: BUS_W];
                    end
                end
            end

            S_RD: begin
                // Issue and return advance independently; both may move in
                // the same cycle.
                if (gnt_fire) begin
                    if (iss_beat_q == LAST_BEAT) begin
                        iss_beat_d = '0;
                        iss_done_d = 1'b1;
                        bus_req_d  = 1'b0;
                    end else begin
                        iss_beat_d = iss_beat_nx;
                        bus_addr_d = {tag_q, iss_lane_nx, {WOFF_W{1'b0}}};
                    end
                end
                if (rv_fire) begin
                    lbuf_d[int'(ret_lane) * BUS_W +: BUS_W] = bus_rdata;
                    if (ret_beat_q == LAST_BEAT) begin
                        ret_beat_d   = '0;
                        ret_done_d   = 1'b1;
                        resp_ready_d = 1'b1;
                        resp_data_d  = lbuf_d;
                        state_d      = S_RESP;
                    end else begin
                        ret_beat_d = ret_beat_q + BEAT_W'(1);
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            wline_q      <= '0;
            b0_q         <= '0;
            iss_beat_q   <= '0;
            iss_done_q   <= 1'b0;
            ret_beat_q   <= '0;
            ret_done_q   <= 1'b0;
            lbuf_q       <= '0;
            resp_ready_q <= 1'b0;
            resp_data_q  <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            wline_q      <= wline_d;
            b0_q         <= b0_d;
            iss_beat_q   <= iss_beat_d;
            iss_done_q   <= iss_done_d;
            ret_beat_q   <= ret_beat_d;
            ret_done_q   <= ret_done_d;
            lbuf_q       <= lbuf_d;
            resp_ready_q <= resp_ready_d;
            resp_data_q  <= resp_data_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign mem_resp_ready = resp_ready_q;
    assign mem_resp_data  = resp_data_q;
    assign bus_req        = bus_req_q;
    assign bus_we         = bus_we_q;
    assign bus_addr       = bus_addr_q;
    assign bus_wdata      = bus_wdata_q;

endmodule

// File: tb/tb_cache_membus_adapter.sv
// -----------------------------------------------------------------------------
// tb_cache_membus_adapter
//
// Directed bench for cache_membus_adapter. A small bus responder grants
// beats (with an optional stall on one address) and returns read words a
// fixed number of cycles after each read grant. Every granted beat and every
// ready pulse is logged on the falling edge and compared against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_cache_membus_adapter;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_req_valid = 1'b0;
    logic          mem_req_rw = 1'b0;
    logic [31:0]   mem_req_addr = '0;
    logic [127:0]  mem_req_data = '0;
    logic          mem_resp_ready;
    logic [127:0]  mem_resp_data;
    logic          bus_req;
    logic          bus_we;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_gnt = 1'b0;
    logic          bus_rvalid = 1'b0;
    logic [31:0]   bus_rdata = '0;

    cache_membus_adapter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: high half tracks the line address, low byte is 0x11
    // times (word index + 1), so line 0x4000 holds 0x40000011..0x40000044.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] lo;
        lo = 8'h11 * (8'(a[3:2]) + 8'd1);
        return {a[15:4], 12'h000, lo};
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          at;
    } beat_t;

    beat_t        beats[$];
    int           due_q[$];
    logic [31:0]  dat_q[$];
    int           rdy_cnt = 0;
    int           rdy_cyc = 0;
    logic [127:0] rdy_data = '0;

    int           rd_lat = 2;
    logic [31:0]  stall_addr = 32'hFFFF_FFFF;
    int           stall_left = 0;
    logic         stray = 1'b0;

    // Responder and monitor: decides grant/rvalid for the next rising edge and
    // logs what that edge will accept.
    always @(negedge clk) begin : bus_model
        bit    g;
        beat_t b;
        g = 1'b1;
        if (bus_req && bus_addr == stall_addr && stall_left > 0) begin
            g = 1'b0;
            stall_left--;
        end
        bus_gnt = g;
        if (bus_req && g) begin
            b.addr  = bus_addr;
            b.wdata = bus_wdata;
            b.we    = bus_we;
            b.at    = cyc + 1;
            beats.push_back(b);
            if (!bus_we) begin
                due_q.push_back(cyc + 1 + rd_lat);
                dat_q.push_back(mem_word(bus_addr));
            end
        end
        if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
            bus_rvalid = 1'b1;
            bus_rdata  = dat_q[0];
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end else if (stray) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hBAD0_BAD0;
        end else begin
            bus_rvalid = 1'b0;
            bus_rdata  = '0;
        end
        if (mem_resp_ready) begin
            rdy_cnt++;
            rdy_cyc  = cyc;
            rdy_data = mem_resp_data;
        end
    end

    task automatic clear_mon();
        beats.delete();
        rdy_cnt = 0;
    endtask

    // Presents a one-cycle request, then scrambles the request inputs to show
    // the adapter latched them. t_start is the cycle count when it was driven.
    task automatic issue_req(input logic rw, input logic [31:0] addr,
                             input logic [127:0] data, output int t_start);
        @(negedge clk);
        t_start       = cyc;
        mem_req_valid = 1'b1;
        mem_req_rw    = rw;
        mem_req_addr  = addr;
        mem_req_data  = data;
        @(negedge clk);
        mem_req_valid = 1'b0;
        mem_req_rw    = ~rw;
        mem_req_addr  = 32'hFFFF_FFF0;
        mem_req_data  = '1;
    endtask

    localparam logic [127:0] LINE_4000 = 128'h40000044_40000033_40000022_40000011;
    localparam logic [127:0] LINE_5000 = 128'h50000044_50000033_50000022_50000011;
    localparam logic [127:0] LINE_7000 = 128'h70000044_70000033_70000022_70000011;

    initial begin
        int t0;
        int n;
        int r;
        logic [31:0] exp_w[4];
        logic [31:0] exp_a[4];

        // ---- reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_req",   128'(bus_req),        128'h0);
        check_val("rst_we",    128'(bus_we),         128'h0);
        check_val("rst_addr",  128'(bus_addr),       128'h0);
        check_val("rst_wdata", 128'(bus_wdata),      128'h0);
        check_val("rst_ready", 128'(mem_resp_ready), 128'h0);
        check_val("rst_rdata", mem_resp_data,        128'h0);
        reset_n = 1'b1;

        // ---- write-back, grant always high
        clear_mon();
        issue_req(1'b1, 32'h0000_1230, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, t0);
        repeat (10) @(negedge clk);
        exp_w = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
        exp_a = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
        check_val("wr_nbeats", 128'(beats.size()), 128'd4);
        for (int k = 0; k < 4 && k < beats.size(); k++) begin
            check_val($sformatf("wr_addr%0d", k),  128'(beats[k].addr),  128'(exp_a[k]));
            check_val($sformatf("wr_wdata%0d", k), 128'(beats[k].wdata), 128'(exp_w[k]));
            check_val($sformatf("wr_we%0d", k),    128'(beats[k].we),    128'h1);
        end
        check_val("wr_pulses", 128'(rdy_cnt), 128'd1);
        check_val("wr_latency", 128'(rdy_cyc - t0 + 1), 128'd6);
        check_val("wr_req_low", 128'(bus_req), 128'h0);

        // ---- fill, rvalid two cycles after each grant
        clear_mon();
        issue_req(1'b0, 32'h0000_4000, 128'h0, t0);
        repeat (12) @(negedge clk);
        exp_a = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
        check_val("rd_nbeats", 128'(beats.size()), 128'd4);
        for (int k = 0; k < 4 && k < beats.size(); k++) begin
            check_val($sformatf("rd_addr%0d", k), 128'(beats[k].addr), 128'(exp_a[k]));
            check_val($sformatf("rd_we%0d", k),   128'(beats[k].we),   128'h0);
        end
        check_val("rd_pulses", 128'(rdy_cnt), 128'd1);
        check_val("rd_line", rdy_data, LINE_4000);
        check_val("rd_latency", 128'(rdy_cyc - t0 + 1), 128'd8);
        check_val("rd_line_hold", mem_resp_data, LINE_4000);
        check_val("rd_ready_low", 128'(mem_resp_ready), 128'h0);

        // ---- write with a 3-cycle grant stall on beat 2
        clear_mon();
        stall_addr = 32'h0000_1238;
        stall_left = 3;
        issue_req(1'b1, 32'h0000_1230, 128'h44444444_33333333_22222222_11111111, t0);
        repeat (3) @(negedge clk);
        check_val("stall_req_a",   128'(bus_req),   128'h1);
        check_val("stall_addr_a",  128'(bus_addr),  128'h1238);
        check_val("stall_wdata_a", 128'(bus_wdata), 128'h33333333);
        @(negedge clk);
        check_val("stall_addr_b",  128'(bus_addr),  128'h1238);
        check_val("stall_wdata_b", 128'(bus_wdata), 128'h33333333);
        repeat (8) @(negedge clk);
        check_val("stall_nbeats", 128'(beats.size()), 128'd4);
        if (beats.size() >= 4) begin
            check_val("stall_b2_at",    128'(beats[2].at - t0),  128'd7);
            check_val("stall_b3_addr",  128'(beats[3].addr),     128'h123C);
            check_val("stall_b3_wdata", 128'(beats[3].wdata),    128'h44444444);
        end
        check_val("stall_pulses", 128'(rdy_cnt), 128'd1);
        check_val("stall_latency", 128'(rdy_cyc - t0 + 1), 128'd9);
        check_val("wr_keeps_rdata", rdy_data, LINE_4000);
        stall_addr = 32'hFFFF_FFFF;

        // ---- write-back then fill, valid held through the pulse
        clear_mon();
        @(negedge clk);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = 32'h0000_2000;
        mem_req_data  = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
        n = 0;
        @(negedge clk);
        while (!mem_resp_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        r = cyc;
        check_val("b2b_wr_pulse", 128'(mem_resp_ready), 128'h1);
        mem_req_rw   = 1'b0;
        mem_req_addr = 32'h0000_5000;
        @(negedge clk);
        check_val("b2b_gap_req", 128'(bus_req), 128'h0);
        @(negedge clk);
        check_val("b2b_rd_req",  128'(bus_req),  128'h1);
        check_val("b2b_rd_we",   128'(bus_we),   128'h0);
        check_val("b2b_rd_addr", 128'(bus_addr), 128'h5000);
        mem_req_valid = 1'b0;
        repeat (12) @(negedge clk);
        check_val("b2b_pulses", 128'(rdy_cnt), 128'd2);
        check_val("b2b_line", rdy_data, LINE_5000);
        check_val("b2b_nbeats", 128'(beats.size()), 128'd8);
        if (beats.size() >= 5) begin
            check_val("b2b_wr_last", 128'(beats[3].addr), 128'h200C);
            check_val("b2b_rd_first", 128'(beats[4].addr), 128'h5000);
            check_val("b2b_rd_grant_at", 128'(beats[4].at - r), 128'd3);
        end

        // ---- reset in the middle of a fill after two returns
        clear_mon();
        issue_req(1'b0, 32'h0000_6000, 128'h0, t0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        stray   = 1'b1;
        check_val("mid_rst_req",   128'(bus_req),        128'h0);
        check_val("mid_rst_we",    128'(bus_we),         128'h0);
        check_val("mid_rst_addr",  128'(bus_addr),       128'h0);
        check_val("mid_rst_wdata", 128'(bus_wdata),      128'h0);
        check_val("mid_rst_ready", 128'(mem_resp_ready), 128'h0);
        check_val("mid_rst_rdata", mem_resp_data,        128'h0);
        repeat (4) @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mid_rst_no_pulse", 128'(rdy_cnt), 128'd0);
        check_val("mid_rst_idle_req", 128'(bus_req), 128'h0);
        clear_mon();
        issue_req(1'b0, 32'h0000_7000, 128'h0, t0);
        repeat (12) @(negedge clk);
        check_val("post_rst_nbeats", 128'(beats.size()), 128'd4);
        if (beats.size() >= 1) begin
            check_val("post_rst_first", 128'(beats[0].addr), 128'h7000);
        end
        check_val("post_rst_pulses", 128'(rdy_cnt), 128'd1);
        check_val("post_rst_line", rdy_data, LINE_7000);

        // ---- fill requested at word 2; write requested at word 3
        clear_mon();
        issue_req(1'b0, 32'h0000_4008, 128'h0, t0);
        repeat (12) @(negedge clk);
`ifdef MEMBUS_CRITICAL_WORD_FIRST_EN
        exp_a = '{32'h4008, 32'h400C, 32'h4000, 32'h4004};
`else
        exp_a = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
`endif
        check_val("cwf_nbeats", 128'(beats.size()), 128'd4);
        for (int k = 0; k < 4 && k < beats.size(); k++) begin
            check_val($sformatf("cwf_addr%0d", k), 128'(beats[k].addr), 128'(exp_a[k]));
        end
        check_val("cwf_pulses", 128'(rdy_cnt), 128'd1);
        check_val("cwf_line", rdy_data, LINE_4000);

        clear_mon();
        issue_req(1'b1, 32'h0000_800C, 128'h88888888_77777777_66666666_55555555, t0);
        repeat (10) @(negedge clk);
        check_val("wr_off_nbeats", 128'(beats.size()), 128'd4);
        if (beats.size() >= 1) begin
            check_val("wr_off_first_addr",  128'(beats[0].addr),  128'h8000);
            check_val("wr_off_first_wdata", 128'(beats[0].wdata), 128'h55555555);
        end
        check_val("wr_off_pulses", 128'(rdy_cnt), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_membus_adapter.md
Name: cache_membus_adapter

Overview:
- Sits directly downstream of the direct-mapped cache controller, between its 128-bit line-wide memory request/response interface and the 32-bit external memory bus.
- Turns each line request into a burst of LINE_W/BUS_W word beats:
  - a write-back serialises the line out;
  - a line fill gathers the returning words into one 128-bit response.
- Returns a single-cycle ready pulse, which the cache controller consumes to leave its allocate or write_back state.

Parameters:
- BUS_W, 32, external bus data width in bits.
- LINE_W, 128, cache line width in bits; BEATS = LINE_W/BUS_W = 4.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; one clock domain.
- reset_n  in  1  synchronous, active-low reset.
- mem_req_valid  in  1  line request present (held by the cache controller).
- mem_req_rw  in  1  1 = write line (write-back), 0 = read line (fill).
- mem_req_addr  in  ADDR_W  byte address; bits [3:0] ignored for line alignment.
- mem_req_data  in  LINE_W  write-back line, word 0 in [31:0].
- mem_resp_ready  out  1  one-cycle pulse: request complete.
- mem_resp_data  out  LINE_W  assembled fill line, valid while mem_resp_ready = 1.
- bus_req  out  1  beat request.
- bus_we  out  1  beat is a write.
- bus_addr  out  ADDR_W  word-aligned beat address.
- bus_wdata  out  BUS_W  write beat data.
- bus_gnt  in  1  beat accepted when bus_req & bus_gnt.
- bus_rvalid  in  1  read data beat returning, in issue order, latency >= 1 cycle.
- bus_rdata  in  BUS_W  read beat data.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - state = IDLE; all counters = 0.
  - mem_resp_ready = 0, mem_resp_data = 0, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0.
  - Reset mid-burst aborts: no response is generated, and stray bus_rvalid after reset is ignored.
- All outputs are registered.
- IDLE:
  - On mem_req_valid = 1, latch addr[31:4], rw and data.
  - Go to WR if rw = 1, else RD.
  - bus_req rises the cycle after acceptance.
- WR:
  - bus_req = 1, bus_we = 1, bus_addr = {line, beat[1:0], 2'b00}, bus_wdata = word[beat].
  - beat increments on each bus_req & bus_gnt.
  - After the beat-3 grant, bus_req drops the next cycle and state goes to RESP.
  - bus_gnt low stalls with outputs held stable.
- RD:
  - Address beats are issued exactly as in WR, with bus_we = 0.
  - The issue counter (0..4) and the return counter (0..4) run independently, so address issue and data return overlap.
  - bus_rvalid is counted only in RD and only when ret_cnt < issue_cnt; otherwise it is ignored.
  - A grant and an rvalid in the same cycle both update their counters.
  - Each returning word is written to lane ret_cnt of the line buffer.
  - When ret_cnt reaches 4, go to RESP; bus_req is already 0 once issue_cnt = 4.
- RESP:
  - mem_resp_ready = 1 for exactly one cycle; mem_resp_data = line buffer (reads only).
  - For writes, mem_resp_data holds its previous value.
  - Return to IDLE.
  - mem_resp_data holds its last value after the pulse, until the next read completes.
- Back-to-back requests:
  - mem_req_valid seen in the cycle right after the RESP pulse is accepted as a new request.
  - This carries the write-back -> fill sequence without a gap.
- Latency:
  - write: 1 (accept) + 4 granted beats + 1 (RESP) = 6 cycles minimum.
  - read: 1 + 4 issue + final return latency + 1.
- mem_req inputs are ignored outside IDLE; changes mid-burst have no effect.
- Beat counters are 2-bit with a separate done flag; there is no wrap into a fifth beat.

Optional Feature:
- MEMBUS_CRITICAL_WORD_FIRST_EN defined:
  - Read bursts start at beat b0 = mem_req_addr[3:2] and wrap modulo 4 (b0, b0+1, ...).
  - Returning words land in lane (b0 + ret_cnt) mod 4; the assembled line is identical to the non-CWF case.
  - Writes stay in order 0..3.
- Not defined: all bursts start at beat 0, and addr[3:2] is ignored.

Test Plan:
- Write, gnt always 1, addr 0x0000_1230, data {0xDDDD_DDDD, 0xCCCC_CCCC, 0xBBBB_BBBB, 0xAAAA_AAAA} -> beats at 0x1230/34/38/3C with wdata AAAA, BBBB, CCCC, DDDD; mem_resp_ready pulses once at cycle 6.
- Read addr 0x0000_4000, rvalid 2 cycles after each grant, rdata 0x11, 0x22, 0x33, 0x44 -> mem_resp_data = 0x...44_..33_..22_..11 (word 0 = 0x11); single ready pulse.
- Write with bus_gnt low for 3 cycles on beat 2 -> bus_addr = 0x1238 and wdata held stable while stalled; completes after the stall, no extra beats.
- Write-back then read with mem_req_valid held through the ready pulse -> read accepted the cycle after the pulse; first read beat uses the new address.
- reset_n low for 1 cycle during RD after 2 returns -> all outputs 0, no ready pulse; subsequent stray rvalid ignored; next request starts cleanly at beat 0.
- MEMBUS_CRITICAL_WORD_FIRST_EN, read addr 0x0000_4008 -> bus_addr sequence 0x4008, 0x400C, 0x4000, 0x4004; assembled line is identical to the in-order fetch.
